execute: RTL and testbench

EXECUTE -- requirements
Module: execute

---
 rtl/execute_pkg.sv | 82 ++++++++
 rtl/execute_muldiv.sv | 169 ++++++++++++++++
 rtl/execute.sv | 116 +++++++++++
 tb/tb_execute.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared pipeline types for the execute stage: opcodes, stage bundles, mul/div states.
// Optional macro EXEC_MUL_1CYC_EN selects the single-cycle multiplier in muldiv.
package execute_pkg;

  typedef enum logic [4:0] {
    OP_NOP,
    OP_ADDU,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOR,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_LUI,
    OP_LW,
    OP_SW,
    OP_MFHI,
    OP_MFLO,
    OP_MTHI,
    OP_MTLO,
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [31:0] pc;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [15:0] imm;
    logic [4:0]  regw;
    logic        rm;
    logic        wm;
    logic        valid;
  } E_type;

  typedef struct packed {
    logic [31:0] pc;
    op_t         op;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [4:0]  regw;
    logic        rm;
    logic        wm;
  } M_type;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_DONE
  } muldiv_state_t;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic is_muldiv(input op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_mul(input op_t op);
    return op inside {OP_MULT, OP_MULTU};
  endfunction

  function automatic logic md_signed(input op_t op);
    return op inside {OP_MULT, OP_DIV};
  endfunction

  function automatic logic no_regw(input op_t op);
    return is_muldiv(op) || (op inside {OP_MTHI, OP_MTLO, OP_SW});
  endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative multiplier / restoring divider with IDLE/MUL/DIV/DONE FSM.
// EXEC_MUL_1CYC_EN: multiply finishes in a single MUL cycle.
module muldiv
  import execute_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  op_t         op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        commit,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CMAX = (DIV_CYCLES > 32) ? DIV_CYCLES : 32;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BPC  = (32 + DIV_CYCLES - 1) / DIV_CYCLES;
`ifdef EXEC_MUL_1CYC_EN
  localparam int MUL_ITERS = 1;
`else
  localparam int MUL_ITERS = 32;
`endif

  muldiv_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_steps;
  logic [63:0]   r_mcand;
  logic [31:0]   r_mplier;
  logic [63:0]   r_acc;
  logic [31:0]   r_rem;
  logic [31:0]   r_quo;
  logic [31:0]   r_dvs;
  logic [31:0]   r_a;
  logic          r_negq;
  logic          r_negr;
  logic          r_dz;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_na;
  logic          w_nb;
  logic [31:0]   w_ma;
  logic [31:0]   w_mb;
  logic [63:0]   w_acc_n;
  logic [63:0]   w_mul_res;
  logic [31:0]   w_rem;
  logic [31:0]   w_quo;
  logic [5:0]    w_steps;
  logic [32:0]   w_t;
  logic [31:0]   w_q_res;
  logic [31:0]   w_r_res;

  assign w_na = md_signed(op) & a[31];
  assign w_nb = md_signed(op) & b[31];
  assign w_ma = w_na ? (32'd0 - a) : a;
  assign w_mb = w_nb ? (32'd0 - b) : b;

`ifdef EXEC_MUL_1CYC_EN
  assign w_acc_n = 64'(r_mcand[31:0]) * 64'(r_mplier);
`else
  assign w_acc_n = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif
  assign w_mul_res = r_negq ? (64'd0 - w_acc_n) : w_acc_n;

  // BPC restoring steps per cycle so any DIV_CYCLES covers all 32 bits
  always_comb begin
    w_rem   = r_rem;
    w_quo   = r_quo;
    w_steps = r_steps;
    w_t     = '0;
    for (int j = 0; j < BPC; j++) begin
      if (w_steps < 6'd32) begin
        w_t   = {w_rem, w_quo[31]};
        w_quo = {w_quo[30:0], 1'b0};
        if (w_t >= {1'b0, r_dvs}) begin
          w_t      = w_t - {1'b0, r_dvs};
          w_quo[0] = 1'b1;
        end
        w_rem   = w_t[31:0];
        w_steps = w_steps + 6'd1;
      end
    end
  end

  assign w_q_res = r_dz ? DIV0_QUO
                 : (r_negq ? (32'd0 - w_quo) : w_quo);
  assign w_r_res = r_dz ? r_a
                 : (r_negr ? (32'd0 - w_rem) : w_rem);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_steps  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_a      <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (flush) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_mcand  <= {32'd0, w_ma};
            r_mplier <= w_mb;
            r_acc    <= '0;
            r_rem    <= '0;
            r_quo    <= w_ma;
            r_dvs    <= w_mb;
            r_a      <= a;
            r_dz     <= (b == 32'd0);
            r_negq   <= w_na ^ w_nb;
            r_negr   <= w_na;
            r_cnt    <= '0;
            r_steps  <= '0;
            r_state  <= is_mul(op) ? MD_MUL : MD_DIV;
          end
        end
        MD_MUL: begin
          r_acc    <= w_acc_n;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(MUL_ITERS - 1)) begin
            r_hi    <= w_mul_res[63:32];
            r_lo    <= w_mul_res[31:0];
            r_state <= MD_DONE;
          end
        end
        MD_DIV: begin
          r_rem   <= w_rem;
          r_quo   <= w_quo;
          r_steps <= w_steps;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(DIV_CYCLES - 1)) begin
            r_hi    <= w_r_res;
            r_lo    <= w_q_res;
            r_state <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (commit) r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign done = (r_state == MD_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, address generation, HI/LO and mul/div control.
// EXEC_MUL_1CYC_EN (in muldiv) shortens MULT/MULTU to one iteration cycle.
module execute
  import execute_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic  clk,
  input  logic  reset,
  input  E_type E,
  input  logic  stall_in,
  input  logic  flush,
  output M_type M_pre,
  output logic  busy
);

  logic        r_inflight;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_commit;
  logic        w_md_done;
  logic [31:0] w_md_hi;
  logic [31:0] w_md_lo;
  logic [31:0] w_alu;
  logic [31:0] w_addr;

  // r_inflight mirrors "muldiv not IDLE" so a held E never restarts it
  assign w_accept = !reset && E.valid && is_muldiv(E.op)
                  && !flush && !r_inflight;
  assign w_commit = !stall_in && !flush;
  assign busy     = !reset
                  && (w_accept || (r_inflight && !w_md_done));

  muldiv #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (w_accept),
    .op    (E.op),
    .a     (E.valA),
    .b     (E.valB),
    .flush (flush),
    .commit(w_commit),
    .done  (w_md_done),
    .hi    (w_md_hi),
    .lo    (w_md_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else if (flush) begin
      r_inflight <= 1'b0;
    end else if (w_accept) begin
      r_inflight <= 1'b1;
    end else if (w_md_done && w_commit) begin
      r_inflight <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_md_done && w_commit) begin
      r_hi <= w_md_hi;
      r_lo <= w_md_lo;
    end else if (E.valid && w_commit) begin
      if (E.op == OP_MTHI) r_hi <= E.valA;
      if (E.op == OP_MTLO) r_lo <= E.valA;
    end
  end

  assign w_addr = E.valA + sext16(E.imm);

  // shifts move valA by valB[4:0]
  always_comb begin
    w_alu = '0;
    unique case (E.op)
      OP_ADDU:  w_alu = E.valA + E.valB;
      OP_SUBU:  w_alu = E.valA - E.valB;
      OP_AND:   w_alu = E.valA & E.valB;
      OP_OR:    w_alu = E.valA | E.valB;
      OP_XOR:   w_alu = E.valA ^ E.valB;
      OP_NOR:   w_alu = ~(E.valA | E.valB);
      OP_SLT:   w_alu = {31'd0, $signed(E.valA) < $signed(E.valB)};
      OP_SLTU:  w_alu = {31'd0, E.valA < E.valB};
      OP_SLL:   w_alu = E.valA << E.valB[4:0];
      OP_SRL:   w_alu = E.valA >> E.valB[4:0];
      OP_SRA:   w_alu = $signed(E.valA) >>> E.valB[4:0];
      OP_LUI:   w_alu = {E.imm, 16'd0};
      OP_LW:    w_alu = w_addr;
      OP_SW:    w_alu = w_addr;
      OP_MFHI:  w_alu = r_hi;
      OP_MFLO:  w_alu = r_lo;
      default:  w_alu = '0;
    endcase
  end

  always_comb begin
    M_pre    = '0;
    M_pre.pc = E.pc;
    if (E.valid) begin
      M_pre.op   = E.op;
      M_pre.valA = w_alu;
      M_pre.valB = E.valB;
      M_pre.rm   = E.rm;
      M_pre.wm   = E.wm;
      M_pre.regw = no_regw(E.op) ? 5'd0 : E.regw;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: ALU, ld/st, HI/LO, mul/div, stall, flush, reset.
// Build with EXEC_MUL_1CYC_EN to expect single-cycle multiplies.
module tb_execute;
  import execute_pkg::*;

  localparam int DIVC = 32;
`ifdef EXEC_MUL_1CYC_EN
  localparam int MULC = 1;
`else
  localparam int MULC = 32;
`endif

  logic  clk = 1'b0;
  logic  reset;
  logic  stall_in;
  logic  flush;
  logic  busy;
  E_type E;
  M_type M_pre;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] pc_n = 32'h100;

  always #5 clk = ~clk;

  execute #(.DIV_CYCLES(DIVC)) dut (
    .clk     (clk),
    .reset   (reset),
    .E       (E),
    .stall_in(stall_in),
    .flush   (flush),
    .M_pre   (M_pre),
    .busy    (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm,
                       input logic [4:0] rw, input logic rm,
                       input logic wm);
    E       = '0;
    E.op    = op;
    E.pc    = pc_n;
    pc_n    = pc_n + 32'd4;
    E.valA  = a;
    E.valB  = b;
    E.imm   = imm;
    E.regw  = rw;
    E.rm    = rm;
    E.wm    = wm;
    E.valid = 1'b1;
  endtask

  task automatic nop();
    E    = '0;
    E.pc = pc_n;
  endtask

  function automatic void md_model(input op_t op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [31:0] hi,
                                   output logic [31:0] lo);
    longint x, y;
    logic [63:0] p;
    int q, r;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = 64'(x * y);
        {hi, lo} = p;
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {hi, lo} = p;
      end
      OP_DIV: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          hi = r; lo = q;
        end
      end
      default: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b want 0", busy);
    end
    set_e(OP_MFHI, 0, 0, 0, 5'd1, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== 32'd0) begin
      errors++; $display("FAIL reset_hi got %h want 0", M_pre.valA);
    end
    set_e(OP_MFLO, 0, 0, 0, 5'd1, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== 32'd0) begin
      errors++; $display("FAIL reset_lo got %h want 0", M_pre.valA);
    end
    nop();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    op_t ops[13] = '{OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
                     OP_SLT, OP_SLTU, OP_SLL, OP_SLL, OP_SRL, OP_SRA,
                     OP_LUI};
    logic [31:0] as[13] = '{32'h7FFF_FFFF, 32'h0, 32'h0F0F_0F0F,
                           32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F,
                           32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h1,
                           32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] bs[13] = '{32'h1, 32'h1, 32'h00FF_00FF, 32'h00FF_00FF,
                           32'h00FF_00FF, 32'h00FF_00FF, 32'h1, 32'h1,
                           32'd31, 32'h23, 32'd31, 32'd4, 32'h5};
    logic [31:0] ex[13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h000F_000F,
                           32'h0FFF_0FFF, 32'h0FF0_0FF0, 32'hF000_F000,
                           32'h1, 32'h0, 32'h8000_0000, 32'h8,
                           32'h1, 32'hF800_0000, 32'h1234_0000};
    logic [31:0] want;
    for (int i = 0; i < 13; i++) begin
      set_e(ops[i], as[i], bs[i], 16'h1234, 5'd5, 0, 0);
      sb_q.push_back(ex[i]);
      #1;
      want = sb_q.pop_front();
      checks++;
      if (M_pre.valA !== want || busy !== 1'b0
          || M_pre.regw !== 5'd5) begin
        errors++;
        $display("FAIL alu_%0d got %h busy %0b regw %0d want %h busy 0 regw 5",
                 i, M_pre.valA, busy, M_pre.regw, want);
      end
      tick();
    end
    nop();
  endtask

  task automatic test_ldst();
    set_e(OP_LW, 32'h1000, 32'h0, 16'hFFFC, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (M_pre.valA !== 32'h0FFC || M_pre.regw !== 5'd3
        || M_pre.rm !== 1'b1 || M_pre.wm !== 1'b0) begin
      errors++;
      $display("FAIL lw got a=%h rw=%0d rm=%0b wm=%0b want 0ffc 3 1 0",
               M_pre.valA, M_pre.regw, M_pre.rm, M_pre.wm);
    end
    tick();
    set_e(OP_SW, 32'hFFFF_FFFF, 32'hCAFE_0001, 16'h0001, 5'd7,
          1'b0, 1'b1);
    #1;
    checks++;
    if (M_pre.valA !== 32'h0 || M_pre.valB !== 32'hCAFE_0001
        || M_pre.regw !== 5'd0 || M_pre.wm !== 1'b1) begin
      errors++;
      $display("FAIL sw got a=%h b=%h rw=%0d wm=%0b want 0 cafe0001 0 1",
               M_pre.valA, M_pre.valB, M_pre.regw, M_pre.wm);
    end
    tick();
    nop();
  endtask

  task automatic test_invalid();
    M_type want;
    set_e(OP_ADDU, 32'h5, 32'h6, 16'h7, 5'd8, 1'b1, 1'b1);
    E.valid = 1'b0;
    E.pc    = 32'h44;
    want    = '0;
    want.pc = 32'h44;
    #1;
    checks++;
    if (M_pre !== want) begin
      errors++; $display("FAIL invalid got %h want %h", M_pre, want);
    end
    tick();
    nop();
  endtask

  task automatic test_mthi_mtlo();
    set_e(OP_MTHI, 32'h1111_2222, 0, 0, 5'd9, 0, 0);
    #1;
    checks++;
    if (M_pre.regw !== 5'd0) begin
      errors++; $display("FAIL mthi_regw got %0d want 0", M_pre.regw);
    end
    tick();
    set_e(OP_MTLO, 32'h3333_4444, 0, 0, 5'd9, 0, 0);
    tick();
    set_e(OP_MTHI, 32'hDEAD_DEAD, 0, 0, 5'd9, 0, 0);
    stall_in = 1'b1;
    tick();
    stall_in = 1'b0;
    m_hi = 32'h1111_2222;
    m_lo = 32'h3333_4444;
    set_e(OP_MFHI, 0, 0, 0, 5'd2, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== m_hi) begin
      errors++; $display("FAIL mfhi got %h want %h", M_pre.valA, m_hi);
    end
    set_e(OP_MFLO, 0, 0, 0, 5'd2, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== m_lo) begin
      errors++; $display("FAIL mflo got %h want %h", M_pre.valA, m_lo);
    end
    tick();
    nop();
  endtask

  task automatic run_md(input op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int stall_n);
    logic [31:0] eh, el, want;
    int n, cyc;
    md_model(op, a, b, eh, el);
    sb_q.push_back(eh);
    sb_q.push_back(el);
    cyc = is_mul(op) ? MULC : DIVC;
    set_e(op, a, b, 0, 5'd9, 0, 0);
    #1;
    checks++;
    if (busy !== 1'b1 || M_pre.regw !== 5'd0) begin
      errors++;
      $display("FAIL md_accept %s busy %0b regw %0d want 1 0",
               op.name(), busy, M_pre.regw);
    end
    n = 0;
    tick();
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (n !== cyc) begin
      errors++;
      $display("FAIL md_busy_cycles %s got %0d want %0d", op.name(), n, cyc);
    end
    set_e(OP_MFHI, 0, 0, 0, 5'd2, 0, 0);
    stall_in = (stall_n > 0);
    for (int s = 0; s < stall_n; s++) begin
      #1;
      checks++;
      if (M_pre.valA !== m_hi || busy !== 1'b0) begin
        errors++;
        $display("FAIL md_stall_hold %0d hi %h busy %0b want %h 0",
                 s, M_pre.valA, busy, m_hi);
      end
      tick();
    end
    stall_in = 1'b0;
    tick();
    #1;
    want = sb_q.pop_front();
    checks++;
    if (M_pre.valA !== want) begin
      errors++;
      $display("FAIL md_hi %s got %h want %h", op.name(), M_pre.valA, want);
    end
    set_e(OP_MFLO, 0, 0, 0, 5'd2, 0, 0);
    #1;
    want = sb_q.pop_front();
    checks++;
    if (M_pre.valA !== want) begin
      errors++;
      $display("FAIL md_lo %s got %h want %h", op.name(), M_pre.valA, want);
    end
    m_hi = eh;
    m_lo = el;
    tick();
    nop();
  endtask

  task automatic test_mul();
    run_md(OP_MULT, 32'hFFFF_FFFF, 32'h2, 0);
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_md(OP_MULT, 32'h1234_5678, 32'hFFFF_0010, 0);
  endtask

  task automatic test_div();
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'h2, 3);
    run_md(OP_DIVU, 32'h5, 32'h0, 0);
    run_md(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0);
    run_md(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1);
  endtask

  task automatic test_flush();
    set_e(OP_DIVU, 32'd1000, 32'd7, 0, 5'd9, 0, 0);
    for (int i = 0; i < 11; i++) tick();
    flush = 1'b1;
    nop();
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy got %0b want 0", busy);
    end
    set_e(OP_MFHI, 0, 0, 0, 5'd2, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== m_hi) begin
      errors++; $display("FAIL flush_hi got %h want %h", M_pre.valA, m_hi);
    end
    set_e(OP_MFLO, 0, 0, 0, 5'd2, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== m_lo) begin
      errors++; $display("FAIL flush_lo got %h want %h", M_pre.valA, m_lo);
    end
    tick();
    nop();
    run_md(OP_DIVU, 32'd1000, 32'd7, 0);
  endtask

  task automatic test_reset_mid_mul();
    set_e(OP_MTHI, 32'h0000_ABCD, 0, 0, 5'd0, 0, 0);
    tick();
    set_e(OP_MULT, 32'd3, 32'd5, 0, 5'd9, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_busy got %0b want 0", busy);
    end
    set_e(OP_MFHI, 0, 0, 0, 5'd2, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== 32'd0) begin
      errors++; $display("FAIL rst_mid_hi got %h want 0", M_pre.valA);
    end
    set_e(OP_MFLO, 0, 0, 0, 5'd2, 0, 0);
    #1;
    checks++;
    if (M_pre.valA !== 32'd0) begin
      errors++; $display("FAIL rst_mid_lo got %h want 0", M_pre.valA);
    end
    m_hi = '0;
    m_lo = '0;
    nop();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_post_busy got %0b want 0", busy);
    end
    tick();
    run_md(OP_MULTU, 32'd6, 32'd7, 0);
  endtask

  initial begin
    reset    = 1'b1;
    stall_in = 1'b0;
    flush    = 1'b0;
    E        = '0;
    tick();
    tick();
    test_reset();
    test_alu();
    test_ldst();
    test_invalid();
    test_mthi_mtlo();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
